// File: rtl/por_reset_sequencer_if.sv
`default_nettype none
// =============================================================================
// por_reset_sequencer_if : trigger/hold controls and reset/status outputs of por_reset_sequencer
// Revision 1.0
// =============================================================================
interface por_reset_sequencer_if #(
  parameter int NUM_CH = 4
);
  localparam int STAGE_W = $clog2(NUM_CH + 1);

  logic               trig_req;
  logic               hold;
  logic [NUM_CH-1:0]  rst_out_n;
  logic [STAGE_W-1:0] stage;
  logic               done;

  modport master (output trig_req, hold, input rst_out_n, stage, done);
  modport slave  (input trig_req, hold, output rst_out_n, stage, done);
endinterface
`default_nettype wire

// File: rtl/por_reset_sequencer.sv
`default_nettype none
// =============================================================================
// por_reset_sequencer : releases NUM_CH active-low resets in order, STAGE_DELAY cycles apart;
//   optional reverse-order teardown on re-trigger via POR_SEQ_REVERSE_EN.   Revision 1.0
// =============================================================================
module por_reset_sequencer #(
  parameter int          NUM_CH      = 4,
  parameter int          DELAY_BITS  = 10,
  parameter int unsigned STAGE_DELAY = 10'h300,
  parameter int          SYNC_STAGES = 2
) (
  input  wire logic            clk,
  input  wire logic            rst_n,
  por_reset_sequencer_if.slave bus_if
);
  localparam int STAGE_W = $clog2(NUM_CH + 1);
  // The RESET->SEQ transition of the state register acts as the last synchroniser stage.
  localparam int SYNC_W  = SYNC_STAGES - 1;
  localparam logic [DELAY_BITS-1:0] CNT_LAST = DELAY_BITS'(STAGE_DELAY - 1);
  localparam logic [STAGE_W-1:0]    LAST_CH  = STAGE_W'(NUM_CH - 1);

  generate
    if (STAGE_DELAY == 0 || 64'(STAGE_DELAY) >= (64'd1 << DELAY_BITS)) begin : g_bad_delay
      $error("por_reset_sequencer: STAGE_DELAY must lie in 1..2**DELAY_BITS-1");
    end
    if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
      $error("por_reset_sequencer: NUM_CH must lie in 1..16");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("por_reset_sequencer: SYNC_STAGES must be at least 2");
    end
  endgenerate

`ifdef POR_SEQ_REVERSE_EN
  typedef enum logic [1:0] {
    ST_RESET    = 2'd0,
    ST_SEQ      = 2'd1,
    ST_DONE     = 2'd2,
    ST_TEARDOWN = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_SEQ   = 2'd1,
    ST_DONE  = 2'd2
  } state_t;
`endif

  state_t              state_q, state_d;
  logic [SYNC_W-1:0]   sync_q;
  logic [DELAY_BITS-1:0] cnt_q, cnt_d;
  logic [STAGE_W-1:0]  stage_q, stage_d;
  logic [NUM_CH-1:0]   rst_out_q, rst_out_d;
  logic                done_q, done_d;
  logic [NUM_CH-1:0]   rel_mask;
`ifdef POR_SEQ_REVERSE_EN
  logic [STAGE_W-1:0]  td_q, td_d;
  logic [NUM_CH-1:0]   drop_mask;
`endif

  always_comb begin
    rel_mask = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      rel_mask[i] = (STAGE_W'(i) == stage_q);
    end
  end

`ifdef POR_SEQ_REVERSE_EN
  always_comb begin
    drop_mask = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      drop_mask[i] = (STAGE_W'(i) == td_q);
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stage_d   = stage_q;
    rst_out_d = rst_out_q;
    done_d    = done_q;
`ifdef POR_SEQ_REVERSE_EN
    td_d      = td_q;
`endif

    if ((state_q == ST_SEQ || state_q == ST_DONE) && bus_if.trig_req) begin
      cnt_d  = '0;
      done_d = 1'b0;
`ifdef POR_SEQ_REVERSE_EN
      // Top channel drops now; lower ones follow one STAGE_DELAY apart.
      rst_out_d[NUM_CH-1] = 1'b0;
      if (stage_q > LAST_CH) begin
        stage_d = LAST_CH;
      end
      if (NUM_CH == 1) begin
        state_d = ST_SEQ;
      end else begin
        state_d = ST_TEARDOWN;
        td_d    = STAGE_W'(NUM_CH - 2);
      end
`else
      rst_out_d = '0;
      stage_d   = '0;
      state_d   = ST_SEQ;
`endif
    end else begin
      case (state_q)
        ST_RESET: begin
          if (sync_q[SYNC_W-1]) begin
            state_d = ST_SEQ;
            cnt_d   = '0;
          end
        end
        ST_SEQ: begin
          if (!bus_if.hold) begin
            if (cnt_q == CNT_LAST) begin
              cnt_d     = '0;
              rst_out_d = rst_out_q | rel_mask;
              stage_d   = stage_q + STAGE_W'(1);
              if (stage_q == LAST_CH) begin
                done_d  = 1'b1;
                state_d = ST_DONE;
              end
            end else begin
              cnt_d = cnt_q + DELAY_BITS'(1);
            end
          end
        end
        ST_DONE: begin
          cnt_d = '0;
        end
`ifdef POR_SEQ_REVERSE_EN
        ST_TEARDOWN: begin
          if (!bus_if.hold) begin
            if (cnt_q == CNT_LAST) begin
              cnt_d     = '0;
              rst_out_d = rst_out_q & ~drop_mask;
              // A partially released sequence only loses stage once teardown reaches it.
              if (stage_q > td_q) begin
                stage_d = td_q;
              end
              if (td_q == '0) begin
                state_d = ST_SEQ;
              end else begin
                td_d = td_q - STAGE_W'(1);
              end
            end else begin
              cnt_d = cnt_q + DELAY_BITS'(1);
            end
          end
        end
`endif
        default: begin
          state_d = ST_RESET;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= '0;
      state_q   <= ST_RESET;
      cnt_q     <= '0;
      stage_q   <= '0;
      rst_out_q <= '0;
      done_q    <= 1'b0;
`ifdef POR_SEQ_REVERSE_EN
      td_q      <= '0;
`endif
    end else begin
      sync_q    <= SYNC_W'({sync_q, 1'b1});
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      stage_q   <= stage_d;
      rst_out_q <= rst_out_d;
      done_q    <= done_d;
`ifdef POR_SEQ_REVERSE_EN
      td_q      <= td_d;
`endif
    end
  end

  assign bus_if.rst_out_n = rst_out_q;
  assign bus_if.stage     = stage_q;
  assign bus_if.done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_por_reset_sequencer.sv
`default_nettype none
// tb_por_reset_sequencer : directed timing points plus randomized trig/hold/abort traffic,
// checked against an elapsed-time model of the release schedule.
module tb_por_reset_sequencer;
  localparam int NUM_CH      = 4;
  localparam int DELAY_BITS  = 4;
  localparam int STAGE_DELAY = 4;
  localparam int SYNC_STAGES = 2;

  localparam int P_RESET = 0;
  localparam int P_RUN   = 1;
  localparam int P_TEAR  = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic hold_lvl = 1'b0;

  por_reset_sequencer_if #(.NUM_CH(NUM_CH)) bus_if ();

  por_reset_sequencer #(
    .NUM_CH      (NUM_CH),
    .DELAY_BITS  (DELAY_BITS),
    .STAGE_DELAY (STAGE_DELAY),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_if (bus_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int edge_no  = 0;
  int rise [NUM_CH];
  int exp_hold [NUM_CH] = '{6, 13, 17, 21};

  // Reference model: progress is elapsed counting edges, not a per-stage counter.
  int m_phase, m_sync, m_ticks, m_tear, m_rel;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at edge %0d: got %0h expected %0h", tag, edge_no, got, exp);
  endtask

  function automatic int m_stage();
    int s;
    case (m_phase)
      P_RUN:   s = (m_ticks / STAGE_DELAY > NUM_CH) ? NUM_CH : m_ticks / STAGE_DELAY;
      P_TEAR: begin
        s = NUM_CH - 1 - m_tear / STAGE_DELAY;
        if (m_rel < s) s = m_rel;
      end
      default: s = 0;
    endcase
    return s;
  endfunction

  task automatic model_reset();
    m_phase = P_RESET; m_sync = 0; m_ticks = 0; m_tear = 0; m_rel = 0;
  endtask

  task automatic model_edge(input logic trig, input logic hld);
    int cur;
    cur = m_stage();
    case (m_phase)
      P_RESET: begin
        m_sync++;
        if (m_sync >= SYNC_STAGES) begin m_phase = P_RUN; m_ticks = 0; end
      end
      P_RUN: begin
        if (trig) begin
`ifdef POR_SEQ_REVERSE_EN
          m_rel = cur; m_tear = 0;
          if (NUM_CH == 1) m_ticks = 0;
          else m_phase = P_TEAR;
`else
          m_ticks = 0;
`endif
        end else if (!hld && cur < NUM_CH) begin
          m_ticks++;
        end
      end
      default: begin
        if (!hld) begin
          m_tear++;
          if (m_tear == (NUM_CH - 1) * STAGE_DELAY) begin m_phase = P_RUN; m_ticks = 0; end
        end
      end
    endcase
  endtask

  task automatic compare_all();
    int s;
    s = m_stage();
    check_eq("rst_out_n", 32'(bus_if.rst_out_n), (32'd1 << s) - 32'd1);
    check_eq("stage", 32'(bus_if.stage), 32'(s));
    check_eq("done", 32'(bus_if.done), 32'(m_phase == P_RUN && s == NUM_CH));
  endtask

  task automatic step(input logic trig, input logic hld);
    bus_if.trig_req = trig;
    bus_if.hold     = hld;
    @(posedge clk);
    if (rst_n) begin
      edge_no++;
      model_edge(trig, hld);
    end
    #1;
    compare_all();
    for (int k = 0; k < NUM_CH; k++)
      if (rise[k] < 0 && bus_if.rst_out_n[k] === 1'b1) rise[k] = edge_no;
  endtask

  task automatic async_abort(input int low_cycles);
    rst_n = 1'b0;
    #1;
    model_reset();
    edge_no = 0;
    compare_all();
    repeat (low_cycles) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    rst_n = 1'b1;
  endtask

  task automatic run_and_record(input int n, input int hold_lo, input int hold_hi);
    for (int k = 0; k < NUM_CH; k++) rise[k] = -1;
    for (int e = 0; e < n; e++) step(1'b0, (edge_no + 1 >= hold_lo) && (edge_no + 1 <= hold_hi));
  endtask

  initial begin
    int r;
    int trig_edge;
    int lat;
    bus_if.trig_req = 1'b0;
    bus_if.hold     = 1'b0;
    for (int k = 0; k < NUM_CH; k++) rise[k] = -1;
    model_reset();
    repeat (5) @(posedge clk);
    #1;
    compare_all();
    rst_n = 1'b1;

    // Power-up release schedule
    run_and_record(20, 0, -1);
    for (int k = 0; k < NUM_CH; k++)
      check_eq("pwrup_rise", 32'(rise[k]), 32'(SYNC_STAGES + (k + 1) * STAGE_DELAY));

    // Hold over edges 7..9
    async_abort(2);
    run_and_record(25, 7, 9);
    for (int k = 0; k < NUM_CH; k++) check_eq("hold_rise", 32'(rise[k]), 32'(exp_hold[k]));

    // Async abort after edge 12, then a clean repeat
    async_abort(3);
    run_and_record(12, 0, -1);
    async_abort(2);
    run_and_record(20, 0, -1);
    for (int k = 0; k < NUM_CH; k++)
      check_eq("abort_rise", 32'(rise[k]), 32'(SYNC_STAGES + (k + 1) * STAGE_DELAY));

    // Re-trigger at edge 100 with done high
    while (edge_no < 99) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    trig_edge = edge_no;
    lat = -1;
    for (int i = 0; i < 60 && lat < 0; i++) begin
      step(1'b0, 1'b0);
      if (bus_if.done === 1'b1) lat = edge_no - trig_edge;
    end
`ifdef POR_SEQ_REVERSE_EN
    check_eq("retrig_done_lat", 32'(lat), 32'(NUM_CH * STAGE_DELAY + (NUM_CH - 1) * STAGE_DELAY));
`else
    check_eq("retrig_done_lat", 32'(lat), 32'(NUM_CH * STAGE_DELAY));
`endif

    // trig_req together with hold while sequencing
    step(1'b1, 1'b0);
    repeat (5) step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    repeat (6) step(1'b0, 1'b1);
    repeat (30) step(1'b0, 1'b0);

    // Randomized traffic
    for (int c = 0; c < 2500; c++) begin
      r = int'($urandom_range(0, 399));
      if (r == 0) begin
        async_abort(int'($urandom_range(1, 3)));
      end else begin
        if ($urandom_range(0, 7) == 0) hold_lvl = ~hold_lvl;
        step(1'($urandom_range(0, 59) == 0), hold_lvl);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
